// File: rtl/pe_job_sequencer.sv
// Job sequencer for a single PE: latches a descriptor, configures the PE, streams filter
// and row-tagged IFM words from a 1-cycle-latency memory, then drains the requested results.
module pe_job_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8,
    parameter int S          = 3,
    parameter int F          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    job_start,
    input  logic [ADDR_WIDTH-1:0]   job_base,
    input  logic [CNT_WIDTH-1:0]    fil_words,
    input  logic [CNT_WIDTH-1:0]    row_len,
    input  logic [CNT_WIDTH-1:0]    rows,
    input  logic [CNT_WIDTH-1:0]    out_count,
    input  logic [S-1:0]            stride_cfg,
    input  logic [F-1:0]            fsize_cfg,
    input  logic [1:0]              mode_cfg,

    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,

    output logic                    pe_start,
    output logic                    pe_w_en_fil,
    output logic [DATA_WIDTH-1:0]   pe_data_fil,
    output logic                    pe_w_en_ifm,
    output logic [DATA_WIDTH+1:0]   pe_data_ifm,
    output logic                    pe_r_en,
    output logic [S-1:0]            pe_stride,
    output logic [F-1:0]            pe_filter_size,
    output logic [1:0]              pe_mode,
    input  logic                    pe_ready_fil,
    input  logic                    pe_ready_ifm,
    input  logic                    pe_valid,
    input  logic [2*DATA_WIDTH-2:0] pe_out,

    output logic                    res_valid,
    output logic [2*DATA_WIDTH-2:0] res_data,
    output logic                    busy,
    output logic                    job_done,
    output logic                    err
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] CFG     = 4'd1;
    localparam logic [3:0] FIL_RD  = 4'd2;
    localparam logic [3:0] FIL_CAP = 4'd3;
    localparam logic [3:0] FIL_WR  = 4'd4;
    localparam logic [3:0] IFM_RD  = 4'd5;
    localparam logic [3:0] IFM_CAP = 4'd6;
    localparam logic [3:0] IFM_WR  = 4'd7;
    localparam logic [3:0] DRAIN   = 4'd8;
    localparam logic [3:0] DONE    = 4'd9;

    logic [3:0]            state;
    logic [3:0]            state_next;

    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  fil_words_q;
    logic [CNT_WIDTH-1:0]  row_len_q;
    logic [CNT_WIDTH-1:0]  rows_q;
    logic [CNT_WIDTH-1:0]  out_count_q;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic [CNT_WIDTH-1:0]  col_cnt;
    logic [CNT_WIDTH-1:0]  row_cnt;
    logic [DATA_WIDTH-1:0] fil_hold;
    logic [DATA_WIDTH+1:0] ifm_hold;
    logic [S-1:0]          stride_q;
    logic [F-1:0]          fsize_q;
    logic [1:0]            mode_q;

    logic job_bad;
    logic accept;
    logic fil_step;
    logic ifm_step;
    logic res_take;
    logic last_fil;
    logic last_col;
    logic last_row;
    logic last_res;

    assign job_bad  = (fil_words == '0) || (row_len == '0) || (rows == '0) || (out_count == '0);
    assign accept   = (state == IDLE) && job_start && !job_bad;
    assign fil_step = (state == FIL_WR) && pe_ready_fil;
    assign ifm_step = (state == IFM_WR) && pe_ready_ifm;
    assign res_take = (state == DRAIN) && pe_valid;

    // Terminal counts are compared before incrementing, so no counter can wrap.
    assign last_fil = (word_cnt == fil_words_q - CNT_WIDTH'(1));
    assign last_col = (col_cnt == row_len_q - CNT_WIDTH'(1));
    assign last_row = (row_cnt == rows_q - CNT_WIDTH'(1));
    assign last_res = (word_cnt == out_count_q - CNT_WIDTH'(1));

    // Control strobes decode straight from the state so an async reset clears them at once.
    assign mem_addr       = addr;
    assign mem_rd         = (state == FIL_RD) || (state == IFM_RD);
    assign pe_start       = (state == CFG);
    assign pe_w_en_fil    = fil_step;
    assign pe_data_fil    = fil_hold;
    assign pe_w_en_ifm    = ifm_step;
    assign pe_data_ifm    = ifm_hold;
    assign pe_r_en        = (state == DRAIN);
    assign pe_stride      = stride_q;
    assign pe_filter_size = fsize_q;
    assign pe_mode        = mode_q;
    assign busy           = (state != IDLE);
    assign job_done       = (state == DONE);

    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CFG;
            CFG:     state_next = FIL_RD;
            FIL_RD:  state_next = FIL_CAP;
            FIL_CAP: state_next = FIL_WR;
            FIL_WR:  if (pe_ready_fil) state_next = last_fil ? IFM_RD : FIL_RD;
            IFM_RD:  state_next = IFM_CAP;
            IFM_CAP: state_next = IFM_WR;
            IFM_WR:  if (pe_ready_ifm) state_next = (last_col && last_row) ? DRAIN : IFM_RD;
            DRAIN:   if (pe_valid && last_res) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fil_words_q <= '0;
            row_len_q   <= '0;
            rows_q      <= '0;
            out_count_q <= '0;
            stride_q    <= '0;
            fsize_q     <= '0;
            mode_q      <= '0;
        end else if (accept) begin
            fil_words_q <= fil_words;
            row_len_q   <= row_len;
            rows_q      <= rows;
            out_count_q <= out_count;
            stride_q    <= stride_cfg;
            fsize_q     <= fsize_cfg;
            mode_q      <= mode_cfg;
        end
    end

    // IFM words follow the filter words contiguously, so one address register serves both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    addr <= '0;
        else if (accept)               addr <= job_base;
        else if (fil_step || ifm_step) addr <= addr + ADDR_WIDTH'(1);
    end

    // word_cnt counts filter words, then is reused to count collected results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (accept) begin
            word_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (fil_step) begin
            word_cnt <= last_fil ? '0 : word_cnt + CNT_WIDTH'(1);
        end else if (ifm_step) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= last_row ? '0 : row_cnt + CNT_WIDTH'(1);
            end else begin
                col_cnt <= col_cnt + CNT_WIDTH'(1);
            end
        end else if (res_take) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
    end

    // Row tags are frozen with the data so they stay stable through a ready stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fil_hold <= '0;
            ifm_hold <= '0;
        end else begin
            if (state == FIL_CAP) fil_hold <= mem_data;
            if (state == IFM_CAP) ifm_hold <= {(col_cnt == '0), last_col, mem_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= res_take;
            if (res_take) res_data <= pe_out;
            err <= (state == IDLE) && job_start && job_bad;
        end
    end

endmodule

// File: tb/tb_pe_job_sequencer.sv
// Self-checking bench for pe_job_sequencer: directed table of jobs, hand-written stall and
// reset sequences, then randomized jobs checked against a transaction-level reference model.
module tb_pe_job_sequencer;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int CW = 8;
    localparam int SW = 3;
    localparam int FW = 4;
    localparam int BUDGET = 2000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            job_start = 1'b0;
    logic [AW-1:0]   job_base = '0;
    logic [CW-1:0]   fil_words = '0;
    logic [CW-1:0]   row_len = '0;
    logic [CW-1:0]   rows = '0;
    logic [CW-1:0]   out_count = '0;
    logic [SW-1:0]   stride_cfg = '0;
    logic [FW-1:0]   fsize_cfg = '0;
    logic [1:0]      mode_cfg = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic [DW-1:0]   mem_data = '0;
    logic            pe_start;
    logic            pe_w_en_fil;
    logic [DW-1:0]   pe_data_fil;
    logic            pe_w_en_ifm;
    logic [DW+1:0]   pe_data_ifm;
    logic            pe_r_en;
    logic [SW-1:0]   pe_stride;
    logic [FW-1:0]   pe_filter_size;
    logic [1:0]      pe_mode;
    logic            pe_ready_fil;
    logic            pe_ready_ifm;
    logic            pe_valid;
    logic [2*DW-2:0] pe_out;
    logic            res_valid;
    logic [2*DW-2:0] res_data;
    logic            busy;
    logic            job_done;
    logic            err;

    pe_job_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .S(SW), .F(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_start(job_start), .job_base(job_base), .fil_words(fil_words),
        .row_len(row_len), .rows(rows), .out_count(out_count),
        .stride_cfg(stride_cfg), .fsize_cfg(fsize_cfg), .mode_cfg(mode_cfg),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .pe_start(pe_start), .pe_w_en_fil(pe_w_en_fil), .pe_data_fil(pe_data_fil),
        .pe_w_en_ifm(pe_w_en_ifm), .pe_data_ifm(pe_data_ifm), .pe_r_en(pe_r_en),
        .pe_stride(pe_stride), .pe_filter_size(pe_filter_size), .pe_mode(pe_mode),
        .pe_ready_fil(pe_ready_fil), .pe_ready_ifm(pe_ready_ifm),
        .pe_valid(pe_valid), .pe_out(pe_out),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .job_done(job_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        int            fw, rl, rw, oc;
        logic [SW-1:0] stride;
        logic [FW-1:0] fsize;
        logic [1:0]    mode;
        bit            rnd_ready, stall, poke;
        bit            exp_err;
        int            exp_fil, exp_ifm, exp_res;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]   mem [1024];
    bit              rdy_rand = 1'b0;
    bit              fil_block = 1'b0;
    bit              ifm_block = 1'b0;

    logic [AW-1:0]   rd_q[$];
    logic [DW-1:0]   fil_q[$];
    logic [DW+1:0]   ifm_q[$];
    logic [2*DW-2:0] res_q[$];
    logic [2*DW-2:0] exp_res[$];
    int              done_n = 0;
    int              start_n = 0;
    int              viol_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input int i);
        return AW'(int'(base) + i);
    endfunction

    function automatic vec_t mkv(input int base, fw, rl, rw, oc, cfg,
                                 input bit rnd, stall, poke, exp_err,
                                 input int exp_fil, exp_ifm, exp_res_n);
        vec_t v;
        v.base = AW'(base);
        v.fw = fw; v.rl = rl; v.rw = rw; v.oc = oc;
        v.stride = cfg[2:0]; v.fsize = cfg[6:3]; v.mode = cfg[8:7];
        v.rnd_ready = rnd; v.stall = stall; v.poke = poke;
        v.exp_err = exp_err;
        v.exp_fil = exp_fil; v.exp_ifm = exp_ifm; v.exp_res = exp_res_n;
        return v;
    endfunction

    // Source memory: one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // PE stand-in: readiness, and results that appear only while read is enabled (plus stray valids).
    initial begin
        pe_ready_fil = 1'b0;
        pe_ready_ifm = 1'b0;
        pe_valid = 1'b0;
        pe_out = '0;
        forever begin
            @(posedge clk);
            #1;
            pe_ready_fil = !fil_block && (!rdy_rand || ($urandom_range(0, 2) != 0));
            pe_ready_ifm = !ifm_block && (!rdy_rand || ($urandom_range(0, 2) != 0));
            pe_out = (2*DW-1)'($urandom);
            if (pe_r_en) begin
                pe_valid = ($urandom_range(0, 1) == 1);
                if (pe_valid) exp_res.push_back(pe_out);
            end else begin
                pe_valid = ($urandom_range(0, 3) == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (pe_w_en_fil) begin
            fil_q.push_back(pe_data_fil);
            if (!pe_ready_fil) viol_n++;
        end
        if (pe_w_en_ifm) begin
            ifm_q.push_back(pe_data_ifm);
            if (!pe_ready_ifm) viol_n++;
        end
        if (res_valid) res_q.push_back(res_data);
        if (job_done) done_n++;
        if (pe_start) start_n++;
    end

    task automatic run_job(input vec_t j);
        int rd0, fil0, ifm0, res0, exp0, done0, start0, viol0, n, wcnt, nifm, col;
        logic [1:0] tag;
        @(negedge clk);
        rd0 = rd_q.size(); fil0 = fil_q.size(); ifm0 = ifm_q.size(); res0 = res_q.size();
        exp0 = exp_res.size(); done0 = done_n; start0 = start_n; viol0 = viol_n;
        rdy_rand = j.rnd_ready;
        job_base = j.base;
        fil_words = CW'(j.fw); row_len = CW'(j.rl); rows = CW'(j.rw); out_count = CW'(j.oc);
        stride_cfg = j.stride; fsize_cfg = j.fsize; mode_cfg = j.mode;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        if (j.exp_err) begin
            check("err_pulse", err, 1);
            check("err_busy_low", busy, 0);
            check("err_no_start", pe_start, 0);
            @(negedge clk);
            check("err_one_cycle", err, 0);
            repeat (4) @(negedge clk);
            check("err_no_mem_rd", rd_q.size() - rd0, 0);
            check("err_busy_after", busy, 0);
            return;
        end
        check("start_after_accept", pe_start, 1);
        check("busy_set", busy, 1);
        check("cfg_stride", pe_stride, j.stride);
        check("cfg_fsize", pe_filter_size, j.fsize);
        check("cfg_mode", pe_mode, j.mode);
        if (j.poke) begin
            job_base = addr_of(j.base, 7);
            fil_words = CW'(j.fw + 2); row_len = CW'(j.rl + 1); rows = CW'(j.rw + 1);
            out_count = CW'(j.oc + 3); stride_cfg = ~j.stride; mode_cfg = ~j.mode;
            job_start = 1'b1;
        end
        @(negedge clk);
        job_start = 1'b0;
        check("start_one_cycle", pe_start, 0);
        if (j.stall) begin
            wcnt = 0; n = 0;
            while (wcnt < 2 && n < 200) begin
                @(negedge clk);
                n++;
                if (pe_w_en_fil) wcnt++;
            end
            check("stall_reach_word3", wcnt, 2);
            repeat (2) @(negedge clk);
            fil_block = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("stall_wen_low", pe_w_en_fil, 0);
                check("stall_data_hold", pe_data_fil, mem[addr_of(j.base, 2)]);
            end
            fil_block = 1'b0;
        end
        n = 0;
        while (!job_done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("job_done_seen", job_done, 1);
        check("busy_at_done", busy, 1);
        @(negedge clk);
        check("done_one_cycle", job_done, 0);
        check("busy_cleared", busy, 0);
        check("r_en_dropped", pe_r_en, 0);
        check("cfg_held", pe_stride, j.stride);

        nifm = j.rw * j.rl;
        check("rd_count", rd_q.size() - rd0, j.fw + nifm);
        for (int i = 0; i < j.fw + nifm && rd0 + i < rd_q.size(); i++)
            check("rd_addr", rd_q[rd0 + i], addr_of(j.base, i));
        check("fil_count", fil_q.size() - fil0, j.exp_fil);
        for (int i = 0; i < j.fw && fil0 + i < fil_q.size(); i++)
            check("fil_data", fil_q[fil0 + i], mem[addr_of(j.base, i)]);
        check("ifm_count", ifm_q.size() - ifm0, j.exp_ifm);
        for (int k = 0; k < nifm && ifm0 + k < ifm_q.size(); k++) begin
            col = k % j.rl;
            tag = {col == 0, col == j.rl - 1};
            check("ifm_word", ifm_q[ifm0 + k], {tag, mem[addr_of(j.base, j.fw + k)]});
        end
        check("res_count", res_q.size() - res0, j.exp_res);
        check("pe_reads_served", exp_res.size() - exp0, j.exp_res);
        for (int i = 0; i < j.oc && res0 + i < res_q.size() && exp0 + i < exp_res.size(); i++)
            check("res_data", res_q[res0 + i], exp_res[exp0 + i]);
        check("start_pulses", start_n - start0, 1);
        check("done_pulses", done_n - done0, 1);
        check("wen_without_ready", viol_n - viol0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t r;
        int   n, wcnt, ifm0, done0;

        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 1);

        //            base  fw rl rw oc cfg   rnd st pk err  fil ifm res
        tbl[0] = mkv(   0,  6, 5, 1, 16, 9'h1b, 0, 0, 0, 0,   6,  5, 16);
        tbl[1] = mkv(   0,  6, 5, 1, 16, 9'h0d, 0, 1, 0, 0,   6,  5, 16);
        tbl[2] = mkv(  40,  2, 1, 3,  4, 9'h15, 0, 0, 0, 0,   2,  3,  4);
        tbl[3] = mkv(   0,  6, 0, 1,  4, 9'h00, 0, 0, 0, 1,   0,  0,  0);
        tbl[4] = mkv(   0,  0, 5, 1,  4, 9'h00, 0, 0, 0, 1,   0,  0,  0);
        tbl[5] = mkv(   0,  6, 5, 0,  4, 9'h00, 0, 0, 0, 1,   0,  0,  0);
        tbl[6] = mkv(   0,  6, 5, 1,  0, 9'h00, 0, 0, 0, 1,   0,  0,  0);
        tbl[7] = mkv(1020,  4, 3, 2,  3, 9'h1ff,1, 0, 0, 0,   4,  6,  3);
        tbl[8] = mkv( 200,  3, 4, 2,  5, 9'h0a2,1, 0, 1, 0,   3,  8,  5);
        tbl[9] = mkv( 300,  1, 2, 1,  1, 9'h107,0, 0, 0, 0,   1,  2,  1);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pe_start", pe_start, 0);
        check("rst_wen", {pe_w_en_fil, pe_w_en_ifm, pe_r_en}, 0);
        check("rst_pulses", {res_valid, job_done, err}, 0);
        check("rst_cfg", {pe_stride, pe_filter_size, pe_mode}, 0);
        check("rst_data", {pe_data_ifm, pe_data_fil, res_data}, 0);
        rst_n = 1'b1;

        // Reset asserted while an IFM word is stalled waiting for ready.
        ifm_block = 1'b1;
        rdy_rand = 1'b0;
        @(negedge clk);
        job_base = '0; fil_words = 8'd2; row_len = 8'd3; rows = 8'd1; out_count = 8'd2;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        wcnt = 0; n = 0;
        while (wcnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (pe_w_en_fil) wcnt++;
        end
        check("rstjob_fil_writes", wcnt, 2);
        repeat (3) @(negedge clk);
        check("rstjob_ifm_stalled", pe_w_en_ifm, 0);
        check("rstjob_ifm_data", pe_data_ifm, {2'b10, mem[2]});
        #2;
        ifm0 = ifm_q.size();
        done0 = done_n;
        rst_n = 1'b0;
        #1;
        check("rstjob_busy", busy, 0);
        check("rstjob_strobes", {mem_rd, pe_w_en_fil, pe_w_en_ifm, pe_r_en, pe_start}, 0);
        check("rstjob_pulses", {res_valid, job_done, err}, 0);
        check("rstjob_ifm_data", pe_data_ifm, 0);
        @(negedge clk);
        ifm_block = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstjob_no_ifm_write", ifm_q.size() - ifm0, 0);
        check("rstjob_no_done", done_n - done0, 0);
        check("rstjob_idle", busy, 0);

        // Directed table; entry 0 doubles as the clean job after the mid-job reset.
        for (int t = 0; t < 10; t++) run_job(tbl[t]);

        // Randomized jobs over random memory contents.
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 30; t++) begin
            r.base = AW'($urandom);
            r.fw = $urandom_range(1, 8);
            r.rl = $urandom_range(1, 5);
            r.rw = $urandom_range(1, 4);
            r.oc = $urandom_range(1, 8);
            r.stride = SW'($urandom);
            r.fsize = FW'($urandom);
            r.mode = 2'($urandom);
            r.rnd_ready = 1'b1;
            r.stall = 1'b0;
            r.poke = ($urandom_range(0, 4) == 0);
            r.exp_err = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: r.fw = 0;
                    1: r.rl = 0;
                    2: r.rw = 0;
                    default: r.oc = 0;
                endcase
                r.exp_err = 1'b1;
            end
            r.exp_fil = r.fw;
            r.exp_ifm = r.rw * r.rl;
            r.exp_res = r.oc;
            run_job(r);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
